mem_bridge: RTL and testbench



---
 rtl/mem_bridge_pkg.sv | 25 ++
 rtl/byte_lane_align.sv | 47 ++++
 rtl/mem_bridge.sv | 198 +++++++++++++++++++
 tb/tb_mem_bridge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the core memory path: bridge FSM states, load/store
// funct3 encodings and the legacy constant still used by other benches.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        MB_IDLE,
        MB_MEM_WAIT,
        MB_IO_WAIT,
        MB_DONE
    } mb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic MEM_NOT_BUSY = 1'b0;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering: store data replication and byte enables from size/offset,
// and load extraction with sign or zero extension.
module byte_lane_align
    import mem_bridge_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_lane_o,
    output logic [3:0]  st_be_o,
    input  logic [2:0]  ld_f3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    always_comb begin
        st_lane_o = st_data_i;
        st_be_o   = 4'b1111;
        case (st_size_i)
            2'b00: begin
                st_lane_o = {4{st_data_i[7:0]}};
                st_be_o   = 4'b0001 << st_off_i;
            end
            2'b01: begin
                st_lane_o = {2{st_data_i[15:0]}};
                st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = ld_raw_i >> {ld_off_i, 3'b000};
        ld_data_o = ld_raw_i;
        case (ld_f3_i)
            F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data_o = {24'd0, shifted[7:0]};
            F3_HU:   ld_data_o = {16'd0, shifted[15:0]};
            default: ld_data_o = ld_raw_i;
        endcase
    end

endmodule

// File: rtl/mem_bridge.sv
// Sequences core loads/stores onto the word-addressed RAM or the IO window,
// reporting completion, busy and access faults back to the core.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] IO_BASE     = 32'h0001_0000,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned IO_TIMEOUT  = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic [2:0]            funct3_i,
    input  logic                  mrd_i,
    input  logic                  mwr_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  rdy_o,
    output logic                  busy_o,
    output logic                  fault_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic [3:0]            mem_be_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    output logic [7:0]            io_addr_o,
    output logic [DATA_WIDTH-1:0] io_wd_o,
    output logic [3:0]            io_be_o,
    output logic                  io_we_o,
    output logic                  io_req_o,
    input  logic                  io_ack_i,
    input  logic [DATA_WIDTH-1:0] io_rd_i
);

    localparam logic [32:0] RAM_END = 33'd4 << ADDR_WIDTH;
    localparam logic [32:0] IO_LO   = {1'b0, IO_BASE};
    localparam logic [32:0] IO_HI   = IO_LO + 33'd256;

    mb_state_e             state_q;
    logic                  armed_q;
    logic [7:0]            cnt_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  rd_op_q;
    logic                  rdy_q, fault_q;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wd_q, io_wd_q;
    logic [3:0]            mem_be_q, io_be_q;
    logic                  mem_we_q, mem_re_q;
    logic [7:0]            io_addr_q;
    logic                  io_we_q, io_req_q;

    logic                  req, accept, in_ram, in_io, misal, fault_d;
    logic [7:0]            io_off;
    logic [DATA_WIDTH-1:0] lane_wd, ld_raw, ld_data;
    logic [3:0]            lane_be;

    assign req     = mrd_i | mwr_i;
    assign accept  = (state_q == MB_IDLE) && req && armed_q;
    assign in_ram  = {1'b0, addr_i} < RAM_END;
    assign in_io   = ({1'b0, addr_i} >= IO_LO) && ({1'b0, addr_i} < IO_HI);
    assign io_off  = addr_i[7:0] - IO_BASE[7:0];
    assign misal   = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign fault_d = !(in_ram || in_io) || (mrd_i && mwr_i) ||
                     !f3_valid(funct3_i) || misal;
    assign ld_raw  = (state_q == MB_IO_WAIT) ? io_rd_i : mem_rd_i;

    // Store lanes come from the live request at accept; loads use the latched offset.
    byte_lane_align u_align (
        .st_size_i (funct3_i[1:0]),
        .st_off_i  (addr_i[1:0]),
        .st_data_i (wd_i),
        .st_lane_o (lane_wd),
        .st_be_o   (lane_be),
        .ld_f3_i   (f3_q),
        .ld_off_i  (off_q),
        .ld_raw_i  (ld_raw),
        .ld_data_o (ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= MB_IDLE;
            armed_q    <= 1'b1;
            cnt_q      <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            rd_op_q    <= 1'b0;
            rdy_q      <= 1'b0;
            fault_q    <= 1'b0;
            rd_q       <= '0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            mem_be_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            io_addr_q  <= '0;
            io_wd_q    <= '0;
            io_be_q    <= '0;
            io_we_q    <= 1'b0;
            io_req_q   <= 1'b0;
        end else begin
            // Re-arm only after the core has let go of the request for a cycle.
            if (!req) armed_q <= 1'b1;
            else if (accept) armed_q <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                MB_IDLE: begin
                    if (accept) begin
                        f3_q    <= funct3_i;
                        off_q   <= addr_i[1:0];
                        rd_op_q <= mrd_i;
                        cnt_q   <= '0;
                        if (fault_d) begin
                            state_q <= MB_DONE;
                            rdy_q   <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (in_ram) begin
                            state_q    <= MB_MEM_WAIT;
                            mem_addr_q <= addr_i[ADDR_WIDTH+1:2];
                            mem_wd_q   <= lane_wd;
                            mem_be_q   <= lane_be;
                            mem_re_q   <= mrd_i;
                            mem_we_q   <= mwr_i;
                        end else begin
                            state_q   <= MB_IO_WAIT;
                            io_addr_q <= io_off;
                            io_wd_q   <= lane_wd;
                            io_be_q   <= lane_be;
                            io_we_q   <= mwr_i;
                            io_req_q  <= 1'b1;
                        end
                    end
                end
                MB_MEM_WAIT: begin
                    if (!rd_op_q) begin
                        state_q <= MB_DONE;
                        rdy_q   <= 1'b1;
                    end else if (cnt_q == 8'(MEM_LATENCY)) begin
                        state_q <= MB_DONE;
                        rdy_q   <= 1'b1;
                        rd_q    <= ld_data;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                MB_IO_WAIT: begin
                    if (io_ack_i) begin
                        state_q  <= MB_DONE;
                        rdy_q    <= 1'b1;
                        rd_q     <= rd_op_q ? ld_data : '0;
                        io_req_q <= 1'b0;
                        io_we_q  <= 1'b0;
                    end else if (cnt_q == 8'(IO_TIMEOUT)) begin
                        state_q  <= MB_DONE;
                        rdy_q    <= 1'b1;
                        fault_q  <= 1'b1;
                        io_req_q <= 1'b0;
                        io_we_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                MB_DONE: begin
                    state_q <= MB_IDLE;
                    rdy_q   <= 1'b0;
                    fault_q <= 1'b0;
                    rd_q    <= '0;
                end
                default: state_q <= MB_IDLE;
            endcase
        end
    end

    assign busy_o = reset_ni &&
                    (accept || (state_q == MB_MEM_WAIT) || (state_q == MB_IO_WAIT));

    assign rd_o       = rd_q;
    assign rdy_o      = rdy_q;
    assign fault_o    = fault_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wd_o   = mem_wd_q;
    assign mem_be_o   = mem_be_q;
    assign mem_we_o   = mem_we_q;
    assign mem_re_o   = mem_re_q;
    assign io_addr_o  = io_addr_q;
    assign io_wd_o    = io_wd_q;
    assign io_be_o    = io_be_q;
    assign io_we_o    = io_we_q;
    assign io_req_o   = io_req_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: a latency-1 instance and a latency-3 instance
// share all inputs; each access is traced cycle by cycle from its accept cycle.
module tb_mem_bridge;
    import mem_bridge_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [31:0] addr_i, wd_i, mem_rd_i, io_rd_i;
    logic [2:0]  funct3_i;
    logic        mrd_i, mwr_i, io_ack_i;

    logic [31:0] rd_o, mem_wd_o, io_wd_o;
    logic        rdy_o, busy_o, fault_o, mem_we_o, mem_re_o, io_we_o, io_req_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_be_o, io_be_o;
    logic [7:0]  io_addr_o;

    logic [31:0] l3_rd, l3_mem_wd, l3_io_wd;
    logic        l3_rdy, l3_busy, l3_fault, l3_mem_we, l3_mem_re, l3_io_we, l3_io_req;
    logic [9:0]  l3_mem_addr;
    logic [3:0]  l3_mem_be, l3_io_be;
    logic [7:0]  l3_io_addr;

    always #5 clk_i = ~clk_i;

    mem_bridge dut (
        .clk_i, .reset_ni, .addr_i, .wd_i, .funct3_i, .mrd_i, .mwr_i,
        .rd_o, .rdy_o, .busy_o, .fault_o,
        .mem_addr_o, .mem_wd_o, .mem_be_o, .mem_we_o, .mem_re_o, .mem_rd_i,
        .io_addr_o, .io_wd_o, .io_be_o, .io_we_o, .io_req_o, .io_ack_i, .io_rd_i
    );

    mem_bridge #(.MEM_LATENCY(3)) dut3 (
        .clk_i, .reset_ni, .addr_i, .wd_i, .funct3_i, .mrd_i, .mwr_i,
        .rd_o(l3_rd), .rdy_o(l3_rdy), .busy_o(l3_busy), .fault_o(l3_fault),
        .mem_addr_o(l3_mem_addr), .mem_wd_o(l3_mem_wd), .mem_be_o(l3_mem_be),
        .mem_we_o(l3_mem_we), .mem_re_o(l3_mem_re), .mem_rd_i,
        .io_addr_o(l3_io_addr), .io_wd_o(l3_io_wd), .io_be_o(l3_io_be),
        .io_we_o(l3_io_we), .io_req_o(l3_io_req), .io_ack_i, .io_rd_i
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Results of the most recent access() call.
    int          lat1, lat3, n_re, n_we, n_io, busy_n, n_extra;
    logic [31:0] data1, data3, st_wd, io_w;
    logic        flt1, busy_t, io_we_seen;
    logic [3:0]  st_be, io_b;
    logic [9:0]  st_addr;
    logic [7:0]  io_a;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic access(input logic [31:0] addr, input logic [2:0] f3, input logic r,
                          input logic w, input logic [31:0] wd, input int hold,
                          input int ack_at);
        lat1 = 0; lat3 = 0; n_re = 0; n_we = 0; n_io = 0; busy_n = 0; n_extra = 0;
        data1 = '0; data3 = '0; st_wd = '0; io_w = '0; flt1 = 1'b0;
        st_be = '0; io_b = '0; st_addr = '0; io_a = '0; io_we_seen = 1'b0;
        addr_i = addr; funct3_i = f3; mrd_i = r; mwr_i = w; wd_i = wd;
        #1 busy_t = busy_o;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c >= hold) begin
                mrd_i = 1'b0;
                mwr_i = 1'b0;
            end
            io_ack_i = (c == ack_at);
            if (mem_re_o) n_re++;
            if (mem_we_o) begin
                n_we++;
                st_be = mem_be_o;
                st_wd = mem_wd_o;
            end
            if (mem_re_o || mem_we_o) st_addr = mem_addr_o;
            if (io_req_o) n_io++;
            if (io_req_o && c == 1) begin
                io_a = io_addr_o; io_w = io_wd_o; io_b = io_be_o; io_we_seen = io_we_o;
            end
            if (busy_o && lat1 == 0) busy_n++;
            if (rdy_o) begin
                if (lat1 == 0) begin
                    lat1 = c; data1 = rd_o; flt1 = fault_o;
                end else n_extra++;
            end
            if (l3_rdy && lat3 == 0) begin
                lat3 = c; data3 = l3_rd;
            end
            if (lat1 != 0 && lat3 != 0 && c > hold + 2) break;
        end
        io_ack_i = 1'b0;
        step();
    endtask

    initial begin
        int stray;
        reset_ni = 1'b0; addr_i = '0; wd_i = '0; funct3_i = '0; mrd_i = 1'b0;
        mwr_i = 1'b0; io_ack_i = 1'b0; mem_rd_i = '0; io_rd_i = '0;
        step(); step();
        check("rst_rdy", 32'(rdy_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rd", rd_o, 32'd0);
        check("rst_strobes", {28'd0, mem_re_o, mem_we_o, io_req_o, fault_o}, 32'd0);
        reset_ni = 1'b1;
        step();

        // LW 0x040, latency 1 and 3
        mem_rd_i = 32'h8000_00F1;
        access(32'h040, F3_W, 1'b1, 1'b0, '0, 1, 0);
        check("lw_busy_T", 32'(busy_t), 32'd1);
        check("lw_lat1", 32'(lat1), 32'd3);
        check("lw_data1", data1, 32'h8000_00F1);
        check("lw_fault", 32'(flt1), 32'd0);
        check("lw_re_cnt", 32'(n_re), 32'd1);
        check("lw_addr", 32'(st_addr), 32'h10);
        check("lw_busy_cyc", 32'(busy_n), 32'd2);
        check("lw_lat3", 32'(lat3), 32'd5);
        check("lw_data3", data3, 32'h8000_00F1);

        mem_rd_i = 32'h80FF_0012;
        access(32'h043, F3_B, 1'b1, 1'b0, '0, 1, 0);
        check("lb_data", data1, 32'hFFFF_FF80);
        access(32'h043, F3_BU, 1'b1, 1'b0, '0, 1, 0);
        check("lbu_data", data1, 32'h0000_0080);
        access(32'h042, F3_H, 1'b1, 1'b0, '0, 1, 0);
        check("lh_data", data1, 32'hFFFF_80FF);
        access(32'h042, F3_HU, 1'b1, 1'b0, '0, 1, 0);
        check("lhu_data", data1, 32'h0000_80FF);

        // SH with the write request held for five cycles
        access(32'h046, F3_H, 1'b0, 1'b1, 32'h1234_ABCD, 5, 0);
        check("sh_we_cnt", 32'(n_we), 32'd1);
        check("sh_be", 32'(st_be), 32'hC);
        check("sh_wd", st_wd, 32'hABCD_ABCD);
        check("sh_addr", 32'(st_addr), 32'h11);
        check("sh_lat", 32'(lat1), 32'd2);
        check("sh_no_rerun", 32'(n_extra), 32'd0);

        access(32'h041, F3_B, 1'b0, 1'b1, 32'h0000_005A, 1, 0);
        check("sb_be", 32'(st_be), 32'h2);
        check("sb_wd", st_wd, 32'h5A5A_5A5A);

        // Faults: misaligned, unmapped, bad funct3, read+write, window edges
        access(32'h041, F3_W, 1'b1, 1'b0, '0, 1, 0);
        check("mis_lat", 32'(lat1), 32'd1);
        check("mis_fault", 32'(flt1), 32'd1);
        check("mis_rd", data1, 32'd0);
        check("mis_strobes", 32'(n_re + n_we + n_io), 32'd0);
        access(32'h0000_2000, F3_W, 1'b1, 1'b0, '0, 1, 0);
        check("unmap_fault", {30'd0, flt1, lat1 == 1}, 32'd3);
        check("unmap_strobes", 32'(n_re + n_we + n_io), 32'd0);
        access(32'h040, 3'b011, 1'b1, 1'b0, '0, 1, 0);
        check("f3_fault", {30'd0, flt1, lat1 == 1}, 32'd3);
        access(32'h040, F3_W, 1'b1, 1'b1, '0, 1, 0);
        check("rdwr_fault", {30'd0, flt1, n_we == 0}, 32'd3);
        access(32'h0000_1000, F3_W, 1'b1, 1'b0, '0, 1, 0);
        check("ram_end_fault", 32'(flt1), 32'd1);
        access(32'h0001_0100, F3_W, 1'b1, 1'b0, '0, 1, 0);
        check("io_end_fault", 32'(flt1), 32'd1);
        mem_rd_i = 32'h0BAD_F00D;
        access(32'h0000_0FFC, F3_W, 1'b1, 1'b0, '0, 1, 1);
        check("ram_top_ok", {30'd0, flt1, lat1 == 3}, 32'd1);
        check("ram_top_addr", 32'(st_addr), 32'h3FF);
        check("ram_top_data", data1, 32'h0BAD_F00D);

        // IO window
        access(32'h0001_0004, F3_W, 1'b0, 1'b1, 32'hCAFE_F00D, 1, 3);
        check("io_sw_addr", 32'(io_a), 32'h04);
        check("io_sw_we", 32'(io_we_seen), 32'd1);
        check("io_sw_be", 32'(io_b), 32'hF);
        check("io_sw_wd", io_w, 32'hCAFE_F00D);
        check("io_sw_lat", 32'(lat1), 32'd4);
        check("io_sw_req_cyc", 32'(n_io), 32'd3);
        io_rd_i = 32'h8001_0000;
        access(32'h0001_0006, F3_H, 1'b1, 1'b0, '0, 1, 1);
        check("io_lh_lat", 32'(lat1), 32'd2);
        check("io_lh_data", data1, 32'hFFFF_8001);
        access(32'h0001_0008, F3_W, 1'b1, 1'b0, '0, 1, 0);
        check("io_to_lat", 32'(lat1), 32'd17);
        check("io_to_fault", 32'(flt1), 32'd1);
        check("io_to_req_cyc", 32'(n_io), 32'd16);
        check("io_to_rd", data1, 32'd0);

        // Reset while the latency-3 read sits in MEM_WAIT
        mem_rd_i = 32'h1111_2222;
        addr_i = 32'h040; funct3_i = F3_W; mrd_i = 1'b1;
        step();
        mrd_i = 1'b0;
        step();
        reset_ni = 1'b0;
        step();
        reset_ni = 1'b1;
        check("rrst_l3_out", {28'd0, l3_rdy, l3_busy, l3_mem_re, l3_fault}, 32'd0);
        check("rrst_l3_rd", l3_rd, 32'd0);
        check("rrst_l3_addr", 32'(l3_mem_addr), 32'd0);
        check("rrst_rdy", 32'(rdy_o), 32'd0);
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rdy_o || l3_rdy || l3_mem_re || mem_re_o) stray++;
        end
        check("rrst_quiet", 32'(stray), 32'd0);
        access(32'h040, F3_W, 1'b1, 1'b0, '0, 1, 0);
        check("post_rst_lat1", 32'(lat1), 32'd3);
        check("post_rst_lat3", 32'(lat3), 32'd5);
        check("post_rst_data3", data3, 32'h1111_2222);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
